// File: rtl/cpu_phase_pkg.sv
// Shared 10-phase instruction-cycle definitions used by the branch-AND block and the PC update unit.
package cpu_phase_pkg;

  localparam int unsigned PHASES       = 10;
  localparam int unsigned AND_PHASE    = 4;
  localparam int unsigned SAMPLE_PHASE = 5;
  localparam int unsigned COMMIT_PHASE = 9;
  localparam int unsigned WIDTH        = 32;

  typedef logic [3:0] phase_t;

  function automatic phase_t phase_next(input phase_t p);
    if (p == phase_t'(PHASES - 1)) begin
      return 4'd0;
    end else begin
      return p + 4'd1;
    end
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Mod-10 phase counter; one instance per block keeps every consumer of the phase scheme aligned.
module phase_counter
  import cpu_phase_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  output phase_t phase_o
);

  phase_t phase_q;
  phase_t phase_d;

  // next phase, wrapping after the last phase of the instruction cycle
  always_comb begin
    phase_d = phase_next(phase_q);
  end

  // phase register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= 4'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/pc_branch_unit.sv
// PC update unit: samples the branch decision and target, commits sequential PC or target once per cycle.
// Optional feature macro BRANCH_STATS_EN adds a saturating taken-branch counter (taken_count).
module pc_branch_unit #(
  parameter int unsigned       WIDTH        = cpu_phase_pkg::WIDTH,
  parameter logic [WIDTH-1:0]  RESET_PC     = {WIDTH{1'b0}},
  parameter int unsigned       SAMPLE_PHASE = cpu_phase_pkg::SAMPLE_PHASE,
  parameter int unsigned       COMMIT_PHASE = cpu_phase_pkg::COMMIT_PHASE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] imm,
  input  logic             hold,
  output logic [WIDTH-1:0] pc,
  output logic             pc_updated,
  output logic             branch_taken,
  output logic             misaligned
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      taken_count
`endif
);

  import cpu_phase_pkg::*;

  localparam phase_t           SAMPLE_P = phase_t'(SAMPLE_PHASE);
  localparam phase_t           COMMIT_P = phase_t'(COMMIT_PHASE);
  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(32'd4);

  phase_t           cont_s;
  logic             sample_s;
  logic             commit_s;
  logic             take_target_s;

  logic [WIDTH-1:0] pc_q,     pc_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             taken_q,  taken_d;
  logic             mis_q,    mis_d;
  logic             upd_q,    upd_d;

  phase_counter u_phase (
    .clk_i   (clock),
    .rst_i   (reset),
    .phase_o (cont_s)
  );

  assign sample_s      = (cont_s == SAMPLE_P);
  assign commit_s      = (cont_s == COMMIT_P) && !hold;
  assign take_target_s = taken_q && (target_q[1:0] == 2'b00);

  // sample/commit next-state logic
  always_comb begin
    pc_d     = pc_q;
    target_d = target_q;
    taken_d  = taken_q;
    mis_d    = mis_q;
    upd_d    = 1'b0;
    if (sample_s) begin
      taken_d  = pc_src;
      target_d = pc_q + imm;
    end else begin
      taken_d  = taken_q;
      target_d = target_q;
    end
    // a misaligned taken target falls back to the sequential PC and raises the sticky flag
    if (commit_s) begin
      upd_d = 1'b1;
      if (take_target_s) begin
        pc_d = target_q;
      end else begin
        pc_d = pc_q + PC_STEP;
        if (taken_q) begin
          mis_d = 1'b1;
        end else begin
          mis_d = mis_q;
        end
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // architectural state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      target_q <= {WIDTH{1'b0}};
      taken_q  <= 1'b0;
      mis_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      target_q <= target_d;
      taken_q  <= taken_d;
      mis_q    <= mis_d;
      upd_q    <= upd_d;
    end
  end

  assign pc           = pc_q;
  assign pc_updated   = upd_q;
  assign branch_taken = taken_q;
  assign misaligned   = mis_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] count_q, count_d;

  // saturating count of committed, aligned taken branches
  always_comb begin
    count_d = count_q;
    if (commit_s && take_target_s && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // statistics register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign taken_count = count_q;
`endif

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter update unit on the consumer side of the branch decision. It samples the registered branch-AND output (branch & ALU-zero, valid from phase 5 of the 10-phase instruction cycle) and computes the branch target. At phase 9 it commits either the sequential PC or the branch target to the PC register that feeds instruction fetch. It runs on the same 10-phase counter scheme as the branch-AND block and must stay phase-aligned with it.

## Interface
- `WIDTH`, 32: PC / immediate width in bits.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `SAMPLE_PHASE`, 5: phase at which `pc_src` is sampled (first phase after the branch-AND latches at phase 4).
- `COMMIT_PHASE`, 9: phase at which the PC is written.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pc_src`  in  1  branch-taken decision from the branch-AND block.
- `imm`  in  WIDTH  sign-extended byte offset from the immediate generator; stable from phase 0 through `SAMPLE_PHASE`.
- `hold`  in  1  suppresses the commit at `COMMIT_PHASE`; the instruction is reissued.
- `pc`  out  WIDTH  current PC. Reset: `RESET_PC`.
- `pc_updated`  out  1  one-cycle pulse after each commit. Reset: 0.
- `branch_taken`  out  1  registered `pc_src` sample. Reset: 0.
- `misaligned`  out  1  sticky flag: a taken target had `target[1:0] != 0`. Reset: 0.

## Operation
- Phase counter `cont` (4 bits) counts 0..9 and wraps to 0; reset value 0. Every cycle it advances by one, independent of `hold`, so it stays aligned with the branch-AND block.
- Edge with `cont == SAMPLE_PHASE`: latch `taken_q <= pc_src` and `target_q <= pc + imm`.
  - Arithmetic is modulo 2^WIDTH; the sum is truncated with no overflow flag.
  - `branch_taken` reflects `taken_q`.
- Edge with `cont == COMMIT_PHASE` and `hold == 0`:
  - If `taken_q` and `target_q[1:0] == 0`: `pc <= target_q`.
  - If `taken_q` and `target_q[1:0] != 0`: `pc <= pc + 4` and `misaligned <= 1`.
  - Otherwise: `pc <= pc + 4`.
  - `pc_updated` is 1 for exactly the following cycle (`cont == 0`).
- Edge with `cont == COMMIT_PHASE` and `hold == 1`: `pc` is unchanged and `pc_updated` stays 0. `taken_q` and `target_q` are retained until the next sample phase overwrites them.
- Wrap-around: `pc = 32'hFFFF_FFFC` with a sequential commit gives `32'h0000_0000`.
- `misaligned` is cleared only by `reset`.
- Reset asserted mid-cycle: all registers return to their reset values immediately. Counting restarts at `cont = 0` after deassertion. No partial commit occurs.

## Timing
- Latency from `pc_src` sample to PC change: 4 cycles (edge at phase 5 to edge at phase 9).
- One PC commit per 10 cycles at most.
- `pc`, `branch_taken`, `misaligned` and `pc_updated` are all registered outputs, with no combinational paths from inputs.
- `pc_src` and `imm` are don't-care outside the `SAMPLE_PHASE` edge; `hold` is don't-care outside the `COMMIT_PHASE` edge.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds output `taken_count` (16 bits): counts committed taken, aligned branches.
  - Saturates at 16'hFFFF; reset value 0.
  - Increments on the same edge as the PC commit; does not count held or misaligned commits.
- `BRANCH_STATS_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `cpu_phase_pkg`:
  - `PHASES = 10`, `AND_PHASE = 4`, `SAMPLE_PHASE = 5`, `COMMIT_PHASE = 9`.
  - `WIDTH`.
  - `typedef logic [3:0] phase_t`.
- Sub-module `phase_counter`: mod-10 counter with asynchronous reset, outputting `phase_t`. It is reusable by the branch-AND block so both share one phase definition.

## Test plan
- Reset then 10 cycles with `pc_src = 0` → `pc` goes 0→4 on the phase-9 edge; `pc_updated` pulses once, at `cont == 0`.
- `pc = 32'h100`, `imm = 32'h20`, `pc_src = 1` at phase 5 → `pc = 32'h120` after phase 9; `branch_taken = 1`.
- `pc = 32'h100`, `imm = 32'hFFFF_FFF0` (−16), taken → `pc = 32'hF0`.
- `imm = 32'h6`, taken → `pc = pc + 4` and `misaligned = 1`, which stays 1 across later cycles until reset.
- `hold = 1` at phase 9 → `pc` unchanged and no pulse; next cycle with `hold = 0` and `pc_src = 0` → `pc + 4`.
- `reset` asserted at phase 7 after a taken sample → `pc = RESET_PC` and `cont = 0`; no target commit afterward. With `BRANCH_STATS_EN`, `taken_count` is 0.
